servant_uart_rx: RTL and testbench
==================================

# servant_uart_rx

Synthesizable UART receiver that consumes the servant serial console stream (GPIO bit `q[0]`, 8N1, LSB first) and buffers received bytes in a small FIFO with a valid/ready output. It sits directly downstream of the SoC's GPIO output in the bench and on hardware, replacing behavioural decoding so that console bytes can be checked cycle-accurately or forwarded to a host link.

## Interface
- `CLKS_PER_BIT`, default 280: `wb_clk` cycles per UART bit (62 ns clock at 57600 baud); legal range 16..65535.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW bytes.
- `wb_clk` in 1: sole clock, rising edge.
- `wb_rst_n` in 1: reset, synchronous, active-low.
- `i_rx` in 1: serial line (`q[0]`), asynchronous to `wb_clk`, idle high.
- `o_data` out 8: FIFO head byte, valid when `o_valid`.
- `o_valid` out 1: FIFO not empty.
- `i_ready` in 1: consumer accepts head byte when `o_valid && i_ready`.
- `o_frame_err` out 1: one-cycle pulse on bad stop bit (or parity error when enabled).
- `o_overflow` out 1: sticky; set when a good byte arrives with FIFO full; cleared only by reset.
- `o_level` out FIFO_AW+1: current FIFO occupancy.

## Operation
- Input path: 2-flop synchronizer on `i_rx`, both flops reset to 1. FSM uses synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
- IDLE: wait for `rx_s`==0; load bit counter with CLKS_PER_BIT/2 - 1 (integer division), go START.
- START: at counter expiry sample `rx_s`; 0 → load CLKS_PER_BIT-1, bit index 0, go DATA; 1 → glitch, return IDLE silently.
- DATA: at each expiry shift `rx_s` into bit[index] (LSB first), reload CLKS_PER_BIT-1; after index 7 go STOP (or PARITY when enabled).
- STOP: at expiry sample `rx_s`. 1 → push byte, go IDLE. 0 → pulse `o_frame_err`, discard byte, go BREAK.
- BREAK: remain until `rx_s`==1, then IDLE (prevents a held-low line generating repeated frames).
- FIFO: 2^FIFO_AW entries, pointers FIFO_AW+1 bits wide, wrap naturally; first-word fall-through; `o_data` is the RAM word at the read pointer.
- Push when full and no pop in the same cycle: byte dropped, `o_overflow` set. Push when full with simultaneous pop: both occur, no overflow, level unchanged.
- Pop with `o_valid`==0 ignored; `o_data` is don't-care when `o_valid`==0.
- Reset mid-frame: FSM to IDLE, FIFO emptied, partial byte discarded; synchronizer flops to 1, so a line held low after reset is seen as a start bit only after its falling edge is sampled (flops go 1→0).

## Timing
- Reset values: `o_valid`=0, `o_frame_err`=0, `o_overflow`=0, `o_level`=0, `o_data`=0.
- `i_rx` to `rx_s`: 2 cycles.
- Byte pushed on the edge ending the stop-sample cycle; `o_valid` high the next cycle (1-cycle push latency). Pop takes effect on the same edge; next head visible the following cycle.
- `o_frame_err` asserted exactly one cycle, the cycle after the stop sample.
- Sampling point: mid-bit ±1 cycle; tolerates ±4% baud mismatch at default CLKS_PER_BIT.
- Back-to-back frames: a new start edge is detected in the cycle after STOP returns to IDLE; no dead bit required.

## Configuration
- `SERVANT_UART_RX_PARITY_EN`: defined → frame is 8E1; PARITY state samples one extra bit after DATA; if the XOR of 8 data bits and the parity bit is 1, pulse `o_frame_err`, discard byte, go to STOP-then-IDLE via normal stop check (a bad stop still enters BREAK). Undefined → 8N1, PARITY state absent.

## Test plan
- Reset, send 0x55 at 280 clk/bit → `o_valid` rises exactly 1 cycle after stop sample, `o_data`=0x55, `o_level`=1; `i_ready`=1 → `o_valid`=0 next cycle.
- Send "Hello" back-to-back, `i_ready`=0 → `o_level`=5, bytes pop in order 0x48,0x65,0x6C,0x6C,0x6F.
- Send 0xA3 with stop bit forced 0 → one-cycle `o_frame_err`, `o_level` unchanged; line held low 3 bit-times then released, next byte 0x0F received correctly.
- Fill 16 bytes with `i_ready`=0, send 17th → `o_overflow`=1, `o_level`=16; repeat with `i_ready` pulsed during the 17th push → no overflow, all 17 bytes delivered.
- 0.3-bit low glitch on idle line → no byte, no `o_frame_err`.
- Assert `wb_rst_n`=0 during bit 4 of 0x81 → after release `o_valid`=0, `o_level`=0; next full 0x81 frame received correctly. With `SERVANT_UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `o_frame_err`, no push.

Source files
------------

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 console receiver with a first-word-fall-through byte FIFO.
// Define SERVANT_UART_RX_PARITY_EN to receive 8E1 frames instead of 8N1.
module servant_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 280,
   parameter int unsigned FIFO_AW      = 4
) (
   input  logic             wb_clk,
   input  logic             wb_rst_n,
   input  logic             i_rx,
   output logic [7:0]       o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_frame_err,
   output logic             o_overflow,
   output logic [FIFO_AW:0] o_level
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam logic [CNT_W-1:0]   HALF_LOAD  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]   BIT_LOAD   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_BREAK  = 3'd4
`ifdef SERVANT_UART_RX_PARITY_EN
      ,ST_PARITY = 3'd5
`endif
   } state_t;

   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             ferr_q, ferr_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic [FIFO_AW:0] level_q, level_d;
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
`ifdef SERVANT_UART_RX_PARITY_EN
   logic             par_err_q, par_err_d;
`endif
   logic [7:0]       mem_q [DEPTH];

   logic tick_c;
   logic push_c;
   logic pop_c;
   logic full_c;
   logic wr_en_c;

   assign tick_c = (cnt_q == '0);

   // Frame decoder: start-bit qualification at half bit, then one sample per bit period.
   always_comb begin
      rx_meta_d = i_rx;
      rx_s_d    = rx_meta_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      ferr_d    = 1'b0;
      push_c    = 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = HALF_LOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick_c) begin
               if (!rx_s_q) begin
                  cnt_d   = BIT_LOAD;
                  idx_d   = 3'd0;
                  state_d = ST_DATA;
`ifdef SERVANT_UART_RX_PARITY_EN
                  par_err_d = 1'b0;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (tick_c) begin
               shreg_d[idx_q] = rx_s_q;
               cnt_d          = BIT_LOAD;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`ifdef SERVANT_UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick_c) begin
               cnt_d   = BIT_LOAD;
               state_d = ST_STOP;
               if (^{shreg_q, rx_s_q}) begin
                  ferr_d    = 1'b1;
                  par_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`endif
         ST_STOP: begin
            if (tick_c) begin
               if (rx_s_q) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                  push_c = ~par_err_q;
`else
                  push_c = 1'b1;
`endif
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before another start bit is accepted.
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping: a push into a full FIFO only succeeds alongside a pop.
   always_comb begin
      pop_c    = valid_q & i_ready;
      full_c   = (level_q == FULL_LEVEL);
      wr_en_c  = push_c & (~full_c | pop_c);
      ovf_d    = ovf_q | (push_c & full_c & ~pop_c);
      wr_ptr_d = wr_ptr_q + (FIFO_AW + 1)'(wr_en_c);
      rd_ptr_d = rd_ptr_q + (FIFO_AW + 1)'(pop_c);
      level_d  = wr_ptr_d - rd_ptr_d;
      valid_d  = (level_d != '0);
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         ferr_q    <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         level_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
`ifdef SERVANT_UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         ferr_q    <= ferr_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         level_q   <= level_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
`ifdef SERVANT_UART_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   // Storage array is not reset; the pointers define which entries are live.
   always_ff @(posedge wb_clk) begin
      if (wr_en_c) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
      end
   end

   assign o_data      = valid_q ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : 8'h00;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_overflow  = ovf_q;
   assign o_level     = level_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Randomized self-checking bench for servant_uart_rx against a queue-based FIFO model.
module tb_servant_uart_rx;

   localparam int unsigned CPB   = 48;
   localparam int unsigned AW    = 4;
   localparam int          DEPTH = 16;
`ifdef SERVANT_UART_RX_PARITY_EN
   localparam int          NB    = 11;
`else
   localparam int          NB    = 10;
`endif
   // Cycle (from the start-bit falling edge) in which the stop bit is sampled.
   localparam int          S_OFF = 2 + CPB / 2 + (NB - 1) * CPB;

   logic          wb_clk = 1'b0;
   logic          wb_rst_n;
   logic          i_rx;
   logic          i_ready;
   logic [7:0]    o_data;
   logic          o_valid;
   logic          o_frame_err;
   logic          o_overflow;
   logic [AW:0]   o_level;

   servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .wb_clk      (wb_clk),
      .wb_rst_n    (wb_rst_n),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overflow  (o_overflow),
      .o_level     (o_level)
   );

   always #5 wb_clk = ~wb_clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] mq [$];
   logic       movf      = 1'b0;
   int         ferr_cnt  = 0;
   int         dut_pops  = 0;
   logic       push_ev   = 1'b0;
   logic [7:0] push_byte = 8'h00;
   logic       rand_ready = 1'b0;
   logic       cap_valid [3];
   logic       cap_ferr  [3];
   logic [AW:0] cap_level;
   logic [7:0] cap_data;
   logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
   int         f0;
   int         p0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference FIFO: good frames enter at the stop-sample edge, pops follow i_ready.
   always @(posedge wb_clk) begin
      if (!wb_rst_n) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         if (i_ready && mq.size() > 0) void'(mq.pop_front());
         if (push_ev) begin
            if (mq.size() < DEPTH) mq.push_back(push_byte);
            else movf = 1'b1;
         end
      end
   end

   always @(negedge wb_clk) begin
      if (o_frame_err) ferr_cnt++;
      if (wb_rst_n && o_valid && i_ready) dut_pops++;
      if (wb_rst_n && i_ready && mq.size() > 0) begin
         check("pop_valid", 32'(o_valid), 32'd1);
         check("pop_data", 32'(o_data), 32'(mq[0]));
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                             input logic pulse_ready, input int abort_at);
      logic [NB-1:0] bits;
      logic          good;
`ifdef SERVANT_UART_RX_PARITY_EN
      bits = {stop_bit, (^b) ^ bad_par, b, 1'b0};
`else
      bits = {stop_bit, b, 1'b0};
`endif
      good      = stop_bit && !bad_par;
      push_byte = b;
      for (int n = 0; n < NB * int'(CPB); n++) begin
         if (n == abort_at) begin
            wb_rst_n = 1'b0;
            i_rx     = 1'b1;
            push_ev  = 1'b0;
            repeat (3) begin @(posedge wb_clk); #1; end
            wb_rst_n = 1'b1;
            return;
         end
         i_rx    = bits[n / int'(CPB)];
         push_ev = good && (n == S_OFF);
         if (pulse_ready) i_ready = (n == S_OFF);
         else if (rand_ready) i_ready = 1'($urandom_range(0, 1));
         if (n >= S_OFF && n <= S_OFF + 2) begin
            cap_valid[n - S_OFF] = o_valid;
            cap_ferr[n - S_OFF]  = o_frame_err;
         end
         if (n == S_OFF + 1) begin
            cap_level = o_level;
            cap_data  = o_data;
         end
         @(posedge wb_clk); #1;
      end
      push_ev = 1'b0;
   endtask

   task automatic idle(input int cycles);
      i_rx = 1'b1;
      repeat (cycles) begin
         if (rand_ready) i_ready = 1'($urandom_range(0, 1));
         @(posedge wb_clk); #1;
      end
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      i_ready    = 1'b1;
      for (int k = 0; k < 64 && mq.size() > 0; k++) begin
         @(posedge wb_clk); #1;
      end
      i_ready = 1'b0;
      check("drain_timeout", 32'(mq.size()), 32'd0);
      check("drain_valid", 32'(o_valid), 32'd0);
      check("drain_level", 32'(o_level), 32'd0);
   endtask

   initial begin
      wb_rst_n = 1'b0;
      i_rx     = 1'b1;
      i_ready  = 1'b0;
      repeat (3) begin @(posedge wb_clk); #1; end
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ferr", 32'(o_frame_err), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      check("rst_level", 32'(o_level), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      wb_rst_n = 1'b1;
      idle(20);

      // Single byte with exact push latency
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
      check("t1_valid_at_stop", 32'(cap_valid[0]), 32'd0);
      check("t1_valid_after", 32'(cap_valid[1]), 32'd1);
      check("t1_level", 32'(cap_level), 32'd1);
      check("t1_data", 32'(cap_data), 32'h55);
      check("t1_no_ferr", 32'(cap_ferr[1]), 32'd0);
      i_ready = 1'b1;
      @(posedge wb_clk); #1;
      i_ready = 1'b0;
      check("t1_pop_valid", 32'(o_valid), 32'd0);
      check("t1_pop_level", 32'(o_level), 32'd0);
      idle(CPB);

      // Back-to-back "Hello"
      for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, 1'b0, 1'b0, -1);
      check("hello_level", 32'(o_level), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("hello_head", 32'(o_data), 32'(hello[i]));
         i_ready = 1'b1;
         @(posedge wb_clk); #1;
         i_ready = 1'b0;
      end
      check("hello_empty", 32'(o_level), 32'd0);

      // Bad stop bit, held-low break, then a clean byte
      f0 = ferr_cnt;
      send_frame(8'hA3, 1'b0, 1'b0, 1'b0, -1);
      check("ferr_at_stop", 32'(cap_ferr[0]), 32'd0);
      check("ferr_pulse", 32'(cap_ferr[1]), 32'd1);
      check("ferr_one_cycle", 32'(cap_ferr[2]), 32'd0);
      check("ferr_level", 32'(o_level), 32'd0);
      i_rx = 1'b0;
      repeat (3 * CPB) begin @(posedge wb_clk); #1; end
      idle(2 * CPB);
      check("break_ferr_count", 32'(ferr_cnt - f0), 32'd1);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
      check("after_break_level", 32'(o_level), 32'd1);
      check("after_break_data", 32'(o_data), 32'h0F);
      check("after_break_ferr", 32'(ferr_cnt - f0), 32'd1);
      drain();

      // Overflow: 17th byte with no pop is dropped, flag is sticky
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
      check("full_level", 32'(o_level), 32'd16);
      check("full_no_ovf", 32'(o_overflow), 32'd0);
      send_frame(8'hE7, 1'b1, 1'b0, 1'b0, -1);
      check("ovf_set", 32'(o_overflow), 32'd1);
      check("ovf_level", 32'(o_level), 32'd16);
      drain();
      check("ovf_sticky", 32'(o_overflow), 32'd1);
      wb_rst_n = 1'b0;
      repeat (2) begin @(posedge wb_clk); #1; end
      wb_rst_n = 1'b1;
      check("ovf_cleared", 32'(o_overflow), 32'd0);

      // Full FIFO with a pop on the push edge: nothing lost
      p0 = dut_pops;
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1, -1);
      check("pushpop_no_ovf", 32'(o_overflow), 32'd0);
      check("pushpop_level", 32'(o_level), 32'd16);
      drain();
      check("all_17_delivered", 32'(dut_pops - p0), 32'd17);

      // Short low glitch on idle line
      f0 = ferr_cnt;
      i_rx = 1'b0;
      repeat (CPB * 3 / 10) begin @(posedge wb_clk); #1; end
      idle(12 * CPB);
      check("glitch_level", 32'(o_level), 32'd0);
      check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

      // Reset during data bit 4, then a full frame
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
      check("pre_reset_level", 32'(o_level), 32'd1);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 5 * CPB + CPB / 2);
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_level", 32'(o_level), 32'd0);
      idle(12 * CPB);
      check("midrst_idle_level", 32'(o_level), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
      check("midrst_next_level", 32'(o_level), 32'd1);
      check("midrst_next_data", 32'(o_data), 32'h81);
      drain();

`ifdef SERVANT_UART_RX_PARITY_EN
      f0 = ferr_cnt;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
      idle(CPB);
      check("parity_ferr", 32'(ferr_cnt - f0), 32'd1);
      check("parity_no_push", 32'(o_level), 32'd0);
`endif

      // Random bytes, random gaps (including none), random consumer
      rand_ready = 1'b1;
      repeat (25) begin
         send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
         idle(int'($urandom_range(0, 2)) * int'(CPB) / 2);
      end
      rand_ready = 1'b0;
      i_ready    = 1'b0;
      idle(2);
      check("rand_level", 32'(o_level), 32'(mq.size()));
      check("rand_ovf", 32'(o_overflow), 32'(movf));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
